// File: rtl/car_sensor_pkg.sv
// Shared definitions for the country-road sensor path and traffic_controller.
//   light_t    : country-road light encoding carried on cntry
//   cs_state_t : sensor conditioner FSM state encoding
package car_sensor_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SERVING = 2'd2,
    FAULT   = 2'd3
  } cs_state_t;

endpackage

// File: rtl/car_sensor_conditioner_debounce.sv
// sensor_debounce: two-flop synchronizer followed by a consecutive-sample
// debouncer for the raw loop detector.
//   clock : rising-edge clock
//   clear : synchronous active-high reset
//   raw   : asynchronous, possibly bouncing detector input
//   level : debounced level; flips after DEBOUNCE_CYCLES consecutive
//           synchronized samples that disagree with it
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic raw,
  output logic level
);

  localparam logic [3:0] CntLast = 4'(DEBOUNCE_CYCLES - 1);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (clear) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= 4'd0;
      level   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability synchronizer
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage p1 -> level: any agreement restarts the run of disagreeing samples
      if (sync_p1 != level) begin
        if (cnt == CntLast) begin
          level <= sync_p1;
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: turns the raw country-road loop detector into a
// car-waiting request for traffic_controller, with a queued-car count and a
// sticky stuck-sensor fault.
//   clock        : rising-edge clock
//   clear        : synchronous active-high reset
//   loop_raw     : raw loop detector, asynchronous
//   cntry        : country-road light state (2'b11 treated as not green)
//   X            : registered car-waiting request
//   car_count    : registered count of queued cars, 0..15
//   sensor_fault : registered sticky stuck-sensor flag
module car_sensor_conditioner
  import car_sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 64
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       loop_raw,
  input  logic [1:0] cntry,
  output logic       X,
  output logic [3:0] car_count,
  output logic       sensor_fault
);

  localparam logic [7:0] StuckLast = 8'(STUCK_CYCLES - 1);

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  logic       level_p0;
  logic       level_p1;
  logic       green;
  logic       rise;
  logic       fall;
  logic [7:0] stuck_cnt;
  logic       stuck_hit;
  cs_state_t  state;
  cs_state_t  state_next;
  logic [3:0] count_next;
  logic       x_next;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock (clock),
    .clear (clear),
    .raw   (loop_raw),
    .level (level_p0)
  );

  assign green     = (cntry == GREEN);
  assign rise      = level_p0 & ~level_p1;
  assign fall      = ~level_p0 & level_p1;
  // Fires on the STUCK_CYCLES-th consecutive debounced-high green edge.
  assign stuck_hit = level_p0 && green && (stuck_cnt == StuckLast);

  always_comb begin
    state_next = state;
    count_next = car_count;
    x_next     = 1'b0;

    // The count freezes once a fault is declared, including on the declaring edge.
    if ((state != FAULT) && !stuck_hit) begin
      if (rise) begin
        count_next = sat_inc(car_count);
      end else if (fall && green) begin
        count_next = sat_dec(car_count);
      end
    end

    if ((state == FAULT) || stuck_hit) begin
      state_next = FAULT;
    end else if (green) begin
      state_next = SERVING;
    end else if (count_next != 4'd0) begin
      state_next = WAITING;
    end else begin
      state_next = IDLE;
    end

    // X is registered, so it is decoded from the next state and count.
    case (state_next)
      WAITING, FAULT: x_next = 1'b1;
      SERVING:        x_next = (count_next != 4'd0);
      default:        x_next = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= IDLE;
      car_count    <= 4'd0;
      X            <= 1'b0;
      sensor_fault <= 1'b0;
      stuck_cnt    <= 8'd0;
      level_p1     <= 1'b0;
    end else begin
      // stage p0 -> p1: edge detect, FSM and output registers
      level_p1  <= level_p0;
      state     <= state_next;
      car_count <= count_next;
      X         <= x_next;
      if (stuck_hit) begin
        sensor_fault <= 1'b1;
      end
      if (level_p0 && green) begin
        if (stuck_cnt != StuckLast) begin
          stuck_cnt <= stuck_cnt + 8'd1;
        end
      end else begin
        stuck_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Scoreboard bench for car_sensor_conditioner (DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=64). Stimulus pushes expected outputs tagged with the
// clock edge after which they must hold; a monitor pops and compares them
// on the falling edge.
module tb_car_sensor_conditioner;
  import car_sensor_pkg::*;

  logic       clock = 1'b0;
  logic       clear;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       X;
  logic [3:0] car_count;
  logic       sensor_fault;

  car_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES(64)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .loop_raw     (loop_raw),
    .cntry        (cntry),
    .X            (X),
    .car_count    (car_count),
    .sensor_fault (sensor_fault)
  );

  always #5 clock = ~clock;

  int edges = 0;
  always @(posedge clock) edges <= edges + 1;

  typedef struct {
    int         cyc;
    logic       x;
    logic [3:0] cnt;
    logic       flt;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_at(input int delta, input logic x, input logic [3:0] cnt,
                           input logic flt, input string name);
    exp_t e;
    e.cyc  = edges + delta;
    e.x    = x;
    e.cnt  = cnt;
    e.flt  = flt;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [3:0] sat15(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  // Monitor
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc < edges) begin
        failures++;
        $display("FAIL %s: check reached at edge %0d, required at edge %0d", cur.name, edges, cur.cyc);
      end else if (X !== cur.x || car_count !== cur.cnt || sensor_fault !== cur.flt) begin
        failures++;
        $display("FAIL %s at edge %0d: got X=%0b car_count=%0d sensor_fault=%0b, want X=%0b car_count=%0d sensor_fault=%0b",
                 cur.name, edges, X, car_count, sensor_fault, cur.x, cur.cnt, cur.flt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    clear    = 1'b1;
    loop_raw = 1'b0;
    cntry    = RED;
    expect_at(2, 1'b0, 4'd0, 1'b0, "reset");
    tick(2);
    clear = 1'b0;
    tick(2);

    // Glitch shorter than the debounce window is ignored
    loop_raw = 1'b1;
    expect_at(7, 1'b0, 4'd0, 1'b0, "glitch_a");
    tick(3);
    loop_raw = 1'b0;
    expect_at(7, 1'b0, 4'd0, 1'b0, "glitch_b");
    tick(10);

    // Arrival on red, departure on green, exact latency
    loop_raw = 1'b1;
    expect_at(6, 1'b0, 4'd0, 1'b0, "arrive_pre");
    expect_at(7, 1'b1, 4'd1, 1'b0, "arrive");
    tick(7);
    cntry    = GREEN;
    loop_raw = 1'b0;
    expect_at(1, 1'b1, 4'd1, 1'b0, "serve");
    expect_at(6, 1'b1, 4'd1, 1'b0, "depart_pre");
    expect_at(7, 1'b0, 4'd0, 1'b0, "depart");
    tick(8);
    cntry = RED;
    tick(2);

    // 17 clean pulses on red saturate the count at 15
    for (int i = 0; i < 17; i++) begin
      loop_raw = 1'b1;
      expect_at(6, (i > 0), sat15(i), 1'b0, "pulse_pre");
      expect_at(7, 1'b1, sat15(i + 1), 1'b0, "pulse");
      tick(8);
      loop_raw = 1'b0;
      tick(8);
    end
    expect_at(1, 1'b1, 4'd15, 1'b0, "saturated");
    tick(1);

    // Stuck sensor on green
    clear = 1'b1;
    expect_at(1, 1'b0, 4'd0, 1'b0, "clear_after_sat");
    tick(1);
    clear    = 1'b0;
    cntry    = GREEN;
    loop_raw = 1'b1;
    expect_at(7, 1'b1, 4'd1, 1'b0, "green_arrive");
    expect_at(69, 1'b1, 4'd1, 1'b0, "stuck_pre");
    expect_at(70, 1'b1, 4'd1, 1'b1, "stuck");
    tick(80);
    loop_raw = 1'b0;
    cntry    = RED;
    expect_at(12, 1'b1, 4'd1, 1'b1, "fault_hold");
    tick(12);

    // Clear mid-debounce with the detector still high
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      loop_raw = 1'b1;
      tick(8);
      loop_raw = 1'b0;
      tick(8);
    end
    expect_at(1, 1'b1, 4'd3, 1'b0, "three_cars");
    tick(1);
    loop_raw = 1'b1;
    tick(3);
    clear = 1'b1;
    expect_at(1, 1'b0, 4'd0, 1'b0, "clear_mid");
    tick(1);
    clear = 1'b0;
    expect_at(6, 1'b0, 4'd0, 1'b0, "rearrive_pre");
    expect_at(7, 1'b1, 4'd1, 1'b0, "rearrive");
    tick(8);

    // Illegal light code is not green: falling edge does not decrement
    cntry    = 2'b11;
    loop_raw = 1'b0;
    expect_at(10, 1'b1, 4'd1, 1'b0, "illegal_not_green");
    tick(10);

    // Pulse on green: rise increments, fall decrements
    cntry    = GREEN;
    loop_raw = 1'b1;
    expect_at(1, 1'b1, 4'd1, 1'b0, "green_serve");
    expect_at(7, 1'b1, 4'd2, 1'b0, "green_rise");
    tick(8);
    loop_raw = 1'b0;
    expect_at(7, 1'b1, 4'd1, 1'b0, "green_fall");
    tick(8);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clock);
    tick(1);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/car_sensor_conditioner.md
CAR_SENSOR_CONDITIONER -- requirements
Module: car_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before the debounced level changes; legal range 1..15.
REQ-002 Parameter STUCK_CYCLES, default 64: consecutive debounced-high cycles during country green that declare a sensor fault; legal range 2..255.
REQ-003 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port clear, input, 1 bit: reset; synchronous, active-high.
REQ-005 Port loop_raw, input, 1 bit: raw country-road loop detector; asynchronous to clock; may bounce.
REQ-006 Port cntry, input, 2 bits: country-road light state fed back from traffic_controller.
REQ-007 Port X, output, 1 bit, registered: car-waiting request driven into traffic_controller.
REQ-008 Port car_count, output, 4 bits, registered: number of cars queued on the country road.
REQ-009 Port sensor_fault, output, 1 bit, registered: sticky stuck-sensor flag.

Function
REQ-010 The block SHALL pass loop_raw through a two-flop synchronizer before any other use.
REQ-011 The debounced level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive edges; any reversion before then SHALL reset the debounce counter to 0.
REQ-012 Each debounced rising edge SHALL increment car_count, saturating at 15.
REQ-013 Each debounced falling edge while cntry==GREEN SHALL decrement car_count, saturating at 0; a falling edge while cntry!=GREEN SHALL leave car_count unchanged.
REQ-014 The FSM SHALL have the states IDLE (car_count==0), WAITING (car_count>0, cntry!=GREEN), SERVING (cntry==GREEN) and FAULT.
REQ-015 Transitions: IDLE->WAITING on an increment with cntry!=GREEN; any non-FAULT state->SERVING when cntry==GREEN; SERVING->WAITING when cntry leaves GREEN with car_count>0; SERVING->IDLE when cntry leaves GREEN with car_count==0; any state->FAULT on stuck detection.
REQ-016 X SHALL equal 1 in WAITING and FAULT, and also in SERVING when car_count>0; otherwise 0.
REQ-017 With loop_raw held stable, X SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new raw level (2 sync + DEBOUNCE_CYCLES + 1 update).
REQ-018 Stuck detection: the debounced level high for STUCK_CYCLES consecutive edges while cntry==GREEN SHALL set sensor_fault; the counter SHALL clear whenever cntry!=GREEN or the debounced level is low.
REQ-019 FAULT SHALL be exited only by clear; in FAULT, X=1 and sensor_fault=1 (fail-safe: the country road keeps getting served), and car_count SHALL hold.
REQ-020 cntry==2'b11 (illegal) SHALL be treated as not GREEN.

Reset
REQ-021 With clear=1 at a rising edge: X=0, car_count=0, sensor_fault=0, state=IDLE, debounced level=0, debounce and stuck counters=0, synchronizer flops=0.
REQ-022 clear SHALL override all other activity, including mid-debounce and FAULT; a raw level still high after clear SHALL be re-debounced from zero and counted as a new arrival.

Structure
REQ-023 The light encoding (RED=2'd0, YELLOW=2'd1, GREEN=2'd2) and the FSM state encoding SHALL live in a shared package also used by traffic_controller.
REQ-024 The synchronizer plus debouncer SHALL be one sub-module, sensor_debounce, with a DEBOUNCE_CYCLES parameter and a single debounced output.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=64, 10 ns clock)
REQ-025 clear=1 for 2 edges, loop_raw=0 -> X=0, car_count=0, sensor_fault=0.
REQ-026 cntry=RED, loop_raw high for 3 cycles then low -> car_count stays 0, X stays 0.
REQ-027 cntry=RED, loop_raw held high -> X=1 and car_count=1 at the 7th edge; then cntry=GREEN, loop_raw low -> car_count=0 and X=0 seven edges later.
REQ-028 cntry=RED, 17 clean pulses (8 high, 8 low cycles each) -> car_count=15, X=1.
REQ-029 cntry=GREEN, loop_raw held high for 80 cycles -> sensor_fault=1 and X=1 at the 64th debounced-high edge; both stay 1 after loop_raw falls, until clear.
REQ-030 With car_count=3, assert clear for 1 edge mid-debounce -> all outputs 0 on that edge; loop_raw still high -> car_count=1 seven edges after clear deasserts.
